// File: rtl/zxuno_ps2_pkg.sv
// zxuno_ps2_pkg: shared PS/2 receiver types, register addresses, status bit positions and prefix codes
package zxuno_ps2_pkg;
  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} ps2_state_t;
  localparam logic [7:0] SCANCODE_REG = 8'h04;
  localparam logic [7:0] STATUS_REG = 8'h05;
  localparam logic [7:0] PFX_E0 = 8'hE0;
  localparam logic [7:0] BRK_F0 = 8'hF0;
  localparam int ST_EMPTY = 7;
  localparam int ST_FULL = 6;
  localparam int ST_OVF = 5;
  localparam int ST_ERR = 4;
endpackage

// File: rtl/ps2_sync_filter.sv
// ps2_sync_filter: two-flop synchroniser and run-length glitch filter; EDGE selects falling-edge pulse or filtered level output
module ps2_sync_filter #(
  parameter int FILTER_LEN = 8,
  parameter bit EDGE = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_out
);
  localparam int CW = $clog2(FILTER_LEN + 1);
  logic r_s1, r_s2, r_lvl, r_lvl_d;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_lvl <= 1'b1;
      r_lvl_d <= 1'b1;
      r_cnt <= '0;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_lvl_d <= r_lvl;
      if (r_s2 == r_lvl) r_cnt <= '0;
      else if (r_cnt == CW'(FILTER_LEN - 1)) begin
        r_lvl <= r_s2;
        r_cnt <= '0;
      end else r_cnt <= r_cnt + 1'b1;
    end
  end
  assign o_out = EDGE ? (r_lvl_d & ~r_lvl) : r_lvl;
endmodule

// File: rtl/ps2_scancode_rx.sv
// ps2_scancode_rx: PS/2 frame receiver with scancode FIFO on the ZX-Uno register port; define PS2_E0_MERGE_EN to fold E0 prefixes into bit 7
module ps2_scancode_rx #(
  parameter int FIFO_AW = 3,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT_CYC = 14000,
  parameter logic [7:0] SCANCODE_REG = zxuno_ps2_pkg::SCANCODE_REG,
  parameter logic [7:0] STATUS_REG = zxuno_ps2_pkg::STATUS_REG
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2clk,
  input  logic       ps2data,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic       code_stb,
  output logic [7:0] code
);
  import zxuno_ps2_pkg::*;
  localparam int CW = FIFO_AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  ps2_state_t r_state, w_state_n;
  logic [7:0] r_shift, w_shift_n, r_code, w_push_byte, w_status, r_addr_d;
  logic [2:0] r_bitcnt, w_bitcnt_n;
  logic r_par, w_par_n, w_good, w_bad, w_tmo_hit, w_push, w_push_ok, w_pop;
  logic w_full, w_empty, w_rd_fall, w_st_clr, w_sel_sc, w_sel_st;
  logic r_rd_d, r_ovf, r_err, r_code_stb, w_fall, w_data;
  logic [TW-1:0] r_tmo;
  logic [FIFO_AW-1:0] r_wp, r_rp;
  logic [CW-1:0] r_cnt;
  logic [7:0] r_mem [2**FIFO_AW];
  logic [3:0] w_cnt4;
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .EDGE(1'b1)) u_clk_filt (
    .clk(clk), .rst(rst), .i_pin(ps2clk), .o_out(w_fall));
  ps2_sync_filter #(.FILTER_LEN(FILTER_LEN), .EDGE(1'b0)) u_data_filt (
    .clk(clk), .rst(rst), .i_pin(ps2data), .o_out(w_data));
  assign w_tmo_hit = (r_state != IDLE) && (r_tmo == TW'(TIMEOUT_CYC));
  always_comb begin
    w_state_n = r_state;
    w_shift_n = r_shift;
    w_bitcnt_n = r_bitcnt;
    w_par_n = r_par;
    w_good = 1'b0;
    w_bad = 1'b0;
    if (w_tmo_hit) begin
      w_state_n = IDLE;
      w_shift_n = '0;
      w_bitcnt_n = '0;
    end else if (w_fall) begin
      case (r_state)
        IDLE: begin
          w_state_n = w_data ? IDLE : DATA;
          w_bitcnt_n = '0;
        end
        DATA: begin
          w_shift_n = {w_data, r_shift[7:1]};
          w_bitcnt_n = r_bitcnt + 1'b1;
          w_state_n = (r_bitcnt == 3'd7) ? PARITY : DATA;
        end
        PARITY: begin
          w_par_n = w_data;
          w_state_n = STOP;
        end
        default: begin
          w_good = w_data & (^{r_shift, r_par});
          w_bad = ~w_good;
          w_state_n = IDLE;
        end
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_bitcnt <= '0;
      r_par <= 1'b0;
      r_tmo <= '0;
    end else begin
      r_state <= w_state_n;
      r_shift <= w_shift_n;
      r_bitcnt <= w_bitcnt_n;
      r_par <= w_par_n;
      r_tmo <= (w_state_n == IDLE || w_fall) ? '0 : r_tmo + 1'b1;
    end
  end
`ifdef PS2_E0_MERGE_EN
  logic r_e0, w_is_e0;
  assign w_is_e0 = r_shift == PFX_E0;
  assign w_push = w_good & ~w_is_e0;
  assign w_push_byte = (r_e0 && !r_shift[7]) ? {1'b1, r_shift[6:0]} : r_shift;
  // F0 after E0 is a break prefix, so the extended marker must survive it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_e0 <= 1'b0;
    else if (w_tmo_hit) r_e0 <= 1'b0;
    else if (w_good) r_e0 <= w_is_e0 | (r_e0 & (r_shift == BRK_F0));
  end
`else
  assign w_push = w_good;
  assign w_push_byte = r_shift;
`endif
  assign w_full = r_cnt == CW'(2**FIFO_AW);
  assign w_empty = r_cnt == '0;
  assign w_rd_fall = r_rd_d & ~zxuno_regrd;
  assign w_pop = w_rd_fall & (r_addr_d == SCANCODE_REG) & ~w_empty;
  assign w_st_clr = w_rd_fall & (r_addr_d == STATUS_REG);
  assign w_push_ok = w_push & (~w_full | w_pop);
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wp] <= w_push_byte;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_d <= 1'b0;
      r_addr_d <= '0;
      r_wp <= '0;
      r_rp <= '0;
      r_cnt <= '0;
      r_ovf <= 1'b0;
      r_err <= 1'b0;
      r_code_stb <= 1'b0;
      r_code <= '0;
    end else begin
      r_rd_d <= zxuno_regrd;
      r_addr_d <= zxuno_addr;
      if (w_push_ok) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CW'(w_push_ok) - CW'(w_pop);
      r_ovf <= (w_push & w_full & ~w_pop) | (r_ovf & ~w_st_clr);
      r_err <= w_bad | w_tmo_hit | (r_err & ~w_st_clr);
      r_code_stb <= w_good;
      if (w_good) r_code <= r_shift;
    end
  end
  assign w_cnt4 = (int'(r_cnt) > 15) ? 4'hF : 4'(r_cnt);
  always_comb begin
    w_status = '0;
    w_status[ST_EMPTY] = w_empty;
    w_status[ST_FULL] = w_full;
    w_status[ST_OVF] = r_ovf;
    w_status[ST_ERR] = r_err;
    w_status[3:0] = w_cnt4;
  end
  assign w_sel_sc = zxuno_addr == SCANCODE_REG;
  assign w_sel_st = zxuno_addr == STATUS_REG;
  assign oe_n = ~(zxuno_regrd & (w_sel_sc | w_sel_st));
  assign dout = oe_n ? 8'h00 : w_sel_sc ? (w_empty ? 8'h00 : r_mem[r_rp]) : w_status;
  assign code_stb = r_code_stb;
  assign code = r_code;
endmodule

// File: tb/tb_ps2_scancode_rx.sv
// tb_ps2_scancode_rx: table-driven frame/read sequences against a scoreboard of expected FIFO bytes
module tb_ps2_scancode_rx;
  localparam int HALF = 30;
  logic clk = 1'b0, rst = 1'b1, ps2clk = 1'b1, ps2data = 1'b1, zxuno_regrd = 1'b0;
  logic [7:0] zxuno_addr = 8'h00;
  logic [7:0] dout, code;
  logic oe_n, code_stb;
  ps2_scancode_rx dut (
    .clk(clk), .rst(rst), .ps2clk(ps2clk), .ps2data(ps2data),
    .zxuno_addr(zxuno_addr), .zxuno_regrd(zxuno_regrd),
    .dout(dout), .oe_n(oe_n), .code_stb(code_stb), .code(code));
  always #5 clk = ~clk;
  typedef enum {SEND, SEND_BAD, SEND_GL, RD_SC, RD_ST} op_t;
  typedef struct {op_t op; logic [7:0] val;} vec_t;
  int nchk = 0, nfail = 0, stb_cnt = 0;
  logic [7:0] exp_q[$];
  bit m_e0 = 1'b0;
  vec_t tbl[$];
  always @(negedge clk) if (code_stb) stb_cnt++;
  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic model_push(input logic [7:0] b);
`ifdef PS2_E0_MERGE_EN
    if (b == 8'hE0) begin
      m_e0 = 1'b1;
      return;
    end
    if (m_e0) begin
      m_e0 = (b == 8'hF0);
      b[7] = 1'b1;
    end
`endif
    if (exp_q.size() < 8) exp_q.push_back(b);
  endtask
  function automatic logic [10:0] frame(input logic [7:0] b, input bit good);
    return {1'b1, good ? ~^b : ^b, b, 1'b0};
  endfunction
  task automatic send_bits(input logic [10:0] f, input int n, input bit glitch);
    for (int i = 0; i < n; i++) begin
      ps2data = f[i];
      tick(HALF / 2);
      if (glitch) begin
        ps2clk = 1'b0;
        tick(3);
        ps2clk = 1'b1;
      end
      tick(HALF / 2);
      ps2clk = 1'b0;
      tick(HALF);
      ps2clk = 1'b1;
    end
    ps2data = 1'b1;
  endtask
  task automatic send(input logic [7:0] b, input bit good, input bit glitch);
    int s0;
    s0 = stb_cnt;
    send_bits(frame(b, good), 11, glitch);
    tick(4 * HALF);
    check("code_stb_count", 8'(stb_cnt - s0), {7'b0, good});
    if (good) begin
      check("code", code, b);
      model_push(b);
    end
  endtask
  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    @(negedge clk);
    zxuno_addr = a;
    zxuno_regrd = 1'b1;
    tick(3);
    check("oe_n_low", {7'b0, oe_n}, 8'h00);
    d = dout;
    zxuno_regrd = 1'b0;
    tick(3);
  endtask
  task automatic read_sc();
    logic [7:0] d, e;
    read_reg(8'h04, d);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'h00;
    check("scancode", d, e);
  endtask
  task automatic read_st(input logic [7:0] e);
    logic [7:0] d;
    read_reg(8'h05, d);
    check("status", d, e);
  endtask
  initial begin
    int s0;
    tbl.push_back('{SEND, 8'h1C});
    tbl.push_back('{RD_SC, 8'h00});
    tbl.push_back('{RD_SC, 8'h00});
    tbl.push_back('{RD_ST, 8'h80});
    for (int i = 1; i <= 9; i++) tbl.push_back('{SEND, 8'(i)});
    tbl.push_back('{RD_ST, 8'h68});
    for (int i = 0; i < 8; i++) tbl.push_back('{RD_SC, 8'h00});
    tbl.push_back('{RD_ST, 8'h80});
    tbl.push_back('{SEND_BAD, 8'h33});
    tbl.push_back('{SEND, 8'h5A});
    tbl.push_back('{RD_ST, 8'h11});
    tbl.push_back('{RD_SC, 8'h00});
    tbl.push_back('{RD_ST, 8'h80});
    tbl.push_back('{SEND_GL, 8'h6B});
    tbl.push_back('{RD_SC, 8'h00});
    tbl.push_back('{RD_ST, 8'h80});
    tick(5);
    check("rst_dout", dout, 8'h00);
    check("rst_oe_n", {7'b0, oe_n}, 8'h01);
    check("rst_code_stb", {7'b0, code_stb}, 8'h00);
    check("rst_code", code, 8'h00);
    rst = 1'b0;
    tick(20);
    for (int i = 0; i < tbl.size(); i++) begin
      case (tbl[i].op)
        SEND:     send(tbl[i].val, 1'b1, 1'b0);
        SEND_BAD: send(tbl[i].val, 1'b0, 1'b0);
        SEND_GL:  send(tbl[i].val, 1'b1, 1'b1);
        RD_SC:    read_sc();
        default:  read_st(tbl[i].val);
      endcase
    end
    s0 = stb_cnt;
    send_bits(frame(8'h77, 1'b1), 5, 1'b0);
    tick(15000);
    check("timeout_no_stb", 8'(stb_cnt - s0), 8'h00);
    send(8'h29, 1'b1, 1'b0);
    read_st(8'h11);
    read_sc();
    read_st(8'h80);
    send(8'hE0, 1'b1, 1'b0);
    send(8'h75, 1'b1, 1'b0);
`ifdef PS2_E0_MERGE_EN
    read_st(8'h01);
`else
    read_st(8'h02);
`endif
    read_sc();
    read_sc();
    send(8'h3C, 1'b1, 1'b0);
    send_bits(frame(8'h44, 1'b1), 5, 1'b0);
    rst = 1'b1;
    tick(3);
    check("midrst_oe_n", {7'b0, oe_n}, 8'h01);
    check("midrst_code", code, 8'h00);
    rst = 1'b0;
    exp_q.delete();
    m_e0 = 1'b0;
    tick(20);
    read_st(8'h80);
    send(8'h2A, 1'b1, 1'b0);
    read_sc();
    read_st(8'h80);
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end
endmodule
